// File: rtl/mmul_parallel_kernel_sequencer.sv
// mmul_parallel_kernel_sequencer
// Sits between the hwpe-ctrl engine FSM and the mmul_parallel kernel wrapper.
// A job is n_iter kernel invocations; each invocation is delimited by n_out
// per-output done pulses from the wrapper. Every output is a register that
// reflects the state being entered, so a pulse is high for exactly the cycle
// its state is occupied. A watchdog and an abort input can end a job early.
module mmul_parallel_kernel_sequencer #(
    parameter int CNT_W = 16,
    parameter int TO_W  = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ctrl_start_i,
    input  logic             ctrl_abort_i,
    input  logic [CNT_W-1:0] cfg_n_iter_i,
    input  logic [CNT_W-1:0] cfg_n_out_i,
    input  logic [TO_W-1:0]  cfg_timeout_i,
    output logic             k_start_o,
    output logic             k_clear_o,
    input  logic             k_done_i,
    input  logic             k_ready_i,
    input  logic             k_idle_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] iter_cnt_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_START    = 3'd2,
        S_RUN      = 3'd3,
        S_WAIT_RDY = 3'd4,
        S_DONE     = 3'd5,
        S_ABORT    = 3'd6
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_n_iter;
    logic [CNT_W-1:0] r_n_out;
    logic [TO_W-1:0]  r_timeout;
    logic [CNT_W-1:0] r_iter_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic [TO_W-1:0]  r_wdog;
    logic             r_ready_seen;
    logic             r_k_start;
    logic             r_k_clear;
    logic             r_busy;
    logic             r_done;
    logic             r_err_timeout;

    state_t           w_state_next;
    logic             w_timeout_hit;
    logic [CNT_W-1:0] w_n_out_eff;
    logic [CNT_W-1:0] w_out_inc;
    logic [CNT_W-1:0] w_iter_inc;
    logic [TO_W-1:0]  w_wdog_inc;
    logic             w_wdog_hit;
    logic             w_last_done;

    // A zero output count still means one done pulse per invocation.
    assign w_n_out_eff = (r_n_out == '0) ? CNT_W'(1) : r_n_out;
    assign w_out_inc   = r_out_cnt + CNT_W'(1);
    assign w_iter_inc  = r_iter_cnt + CNT_W'(1);
    assign w_wdog_inc  = r_wdog + TO_W'(1);
    // The watchdog fires on the cycle its count would reach the limit.
    assign w_wdog_hit  = (r_timeout != '0) && (w_wdog_inc == r_timeout);
    assign w_last_done = k_done_i && (w_out_inc == w_n_out_eff);

    // Next-state decode; abort overrides everything outside IDLE.
    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl_start_i) begin
                    w_state_next = (cfg_n_iter_i == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: w_state_next = S_START;
            S_START: w_state_next = S_RUN;
            S_RUN: begin
                // A done pulse restarts the watchdog, so it cannot time out that cycle.
                if (!k_done_i && w_wdog_hit) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_ABORT;
                end else if (w_last_done) begin
                    if (w_iter_inc == r_n_iter) begin
                        w_state_next = S_DONE;
                    end else if (r_ready_seen || k_ready_i) begin
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (w_wdog_hit) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_ABORT;
                end else if (k_ready_i || k_idle_i) begin
                    w_state_next = S_START;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ABORT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && ctrl_abort_i) begin
            w_state_next  = S_ABORT;
            w_timeout_hit = 1'b0;
        end
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_n_iter      <= '0;
            r_n_out       <= '0;
            r_timeout     <= '0;
            r_iter_cnt    <= '0;
            r_out_cnt     <= '0;
            r_wdog        <= '0;
            r_ready_seen  <= 1'b0;
            r_k_start     <= 1'b0;
            r_k_clear     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_k_clear <= (w_state_next == S_CLEAR) || (w_state_next == S_ABORT);
            r_k_start <= (w_state_next == S_START);
            r_done    <= (w_state_next == S_DONE);
            r_busy    <= (w_state_next != S_IDLE);
            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (ctrl_start_i) begin
                        r_n_iter      <= cfg_n_iter_i;
                        r_n_out       <= cfg_n_out_i;
                        r_timeout     <= cfg_timeout_i;
                        r_iter_cnt    <= '0;
                        r_out_cnt     <= '0;
                        r_wdog        <= '0;
                        r_ready_seen  <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end
                S_START: begin
                    r_out_cnt    <= '0;
                    r_ready_seen <= 1'b0;
                    r_wdog       <= '0;
                end
                S_RUN: begin
                    // An aborted cycle leaves the counters untouched.
                    if (!ctrl_abort_i) begin
                        if (k_done_i) begin
                            r_out_cnt <= w_out_inc;
                            r_wdog    <= '0;
                            if (w_last_done) begin
                                r_iter_cnt <= w_iter_inc;
                            end
                        end else if (r_timeout != '0) begin
                            r_wdog <= w_wdog_inc;
                        end
                        if (k_ready_i) begin
                            r_ready_seen <= 1'b1;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (!ctrl_abort_i && (r_timeout != '0)) begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign k_start_o     = r_k_start;
    assign k_clear_o     = r_k_clear;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_timeout_o = r_err_timeout;
    assign iter_cnt_o    = r_iter_cnt;
    assign out_cnt_o     = r_out_cnt;

endmodule

// File: tb/tb_mmul_parallel_kernel_sequencer.sv
// Directed bench for mmul_parallel_kernel_sequencer: a cycle table for a
// three-invocation job plus hand-written sequences for the corner cases.
// Inputs are driven 1 time unit after a rising edge; outputs are compared
// 1 time unit after the edge that consumed those inputs.
module tb_mmul_parallel_kernel_sequencer;

    localparam int CNT_W = 16;
    localparam int TO_W  = 20;

    logic             clk;
    logic             rst;
    logic             ctrl_start;
    logic             ctrl_abort;
    logic [CNT_W-1:0] cfg_n_iter;
    logic [CNT_W-1:0] cfg_n_out;
    logic [TO_W-1:0]  cfg_timeout;
    logic             k_start;
    logic             k_clear;
    logic             k_done;
    logic             k_ready;
    logic             k_idle;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [CNT_W-1:0] iter_cnt;
    logic [CNT_W-1:0] out_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mmul_parallel_kernel_sequencer #(
        .CNT_W(CNT_W),
        .TO_W (TO_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ctrl_start_i (ctrl_start),
        .ctrl_abort_i (ctrl_abort),
        .cfg_n_iter_i (cfg_n_iter),
        .cfg_n_out_i  (cfg_n_out),
        .cfg_timeout_i(cfg_timeout),
        .k_start_o    (k_start),
        .k_clear_o    (k_clear),
        .k_done_i     (k_done),
        .k_ready_i    (k_ready),
        .k_idle_i     (k_idle),
        .busy_o       (busy),
        .done_o       (done),
        .err_timeout_o(err_timeout),
        .iter_cnt_o   (iter_cnt),
        .out_cnt_o    (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        kdone;
        logic        ready;
        logic        e_busy;
        logic        e_clear;
        logic        e_start;
        logic        e_done;
        logic [15:0] e_iter;
        logic [15:0] e_out;
    } vec_t;

    vec_t tab [20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic s, input logic d, input logic r,
                        input logic b, input logic c, input logic st, input logic dn,
                        input logic [15:0] it, input logic [15:0] ot);
        tab[i].start   = s;
        tab[i].kdone   = d;
        tab[i].ready   = r;
        tab[i].e_busy  = b;
        tab[i].e_clear = c;
        tab[i].e_start = st;
        tab[i].e_done  = dn;
        tab[i].e_iter  = it;
        tab[i].e_out   = ot;
    endtask

    initial begin
        // Job: n_iter=3, n_out=4, ready held high. Row = inputs of one cycle and
        // the outputs after the edge that samples them. Dones outside RUN
        // (rows 1, 2, 7, 18, 19) must not be counted.
        //      i  st dn rd  busy clr str dne iter out
        setv( 0, 1, 0, 1,   1,  1,  0,  0,  0,  0);
        setv( 1, 0, 1, 1,   1,  0,  1,  0,  0,  0);
        setv( 2, 0, 1, 1,   1,  0,  0,  0,  0,  0);
        setv( 3, 0, 1, 1,   1,  0,  0,  0,  0,  1);
        setv( 4, 0, 1, 1,   1,  0,  0,  0,  0,  2);
        setv( 5, 0, 1, 1,   1,  0,  0,  0,  0,  3);
        setv( 6, 0, 1, 1,   1,  0,  1,  0,  1,  4);
        setv( 7, 0, 1, 1,   1,  0,  0,  0,  1,  0);
        setv( 8, 0, 1, 1,   1,  0,  0,  0,  1,  1);
        setv( 9, 0, 0, 1,   1,  0,  0,  0,  1,  1);
        setv(10, 0, 1, 1,   1,  0,  0,  0,  1,  2);
        setv(11, 0, 1, 1,   1,  0,  0,  0,  1,  3);
        setv(12, 0, 1, 1,   1,  0,  1,  0,  2,  4);
        setv(13, 0, 0, 1,   1,  0,  0,  0,  2,  0);
        setv(14, 0, 1, 1,   1,  0,  0,  0,  2,  1);
        setv(15, 0, 1, 1,   1,  0,  0,  0,  2,  2);
        setv(16, 0, 1, 1,   1,  0,  0,  0,  2,  3);
        setv(17, 0, 1, 1,   1,  0,  0,  1,  3,  4);
        setv(18, 0, 1, 1,   0,  0,  0,  0,  3,  4);
        setv(19, 0, 1, 1,   0,  0,  0,  0,  3,  4);

        rst = 1'b1; ctrl_start = 1'b0; ctrl_abort = 1'b0;
        cfg_n_iter = '0; cfg_n_out = '0; cfg_timeout = '0;
        k_done = 1'b0; k_ready = 1'b0; k_idle = 1'b0;
        step();
        step();
        chk("reset_flags", {busy, done, k_clear, k_start, err_timeout}, 5'b0);
        chk("reset_cnts", {iter_cnt, out_cnt}, 32'h0);
        rst = 1'b0;
        step();
        chk("idle_flags", {busy, done, k_clear, k_start, err_timeout}, 5'b0);

        // Three invocations of four outputs each.
        cfg_n_iter = 16'd3; cfg_n_out = 16'd4; cfg_timeout = 20'd100;
        for (int i = 0; i < 20; i++) begin
            ctrl_start = tab[i].start;
            k_done     = tab[i].kdone;
            k_ready    = tab[i].ready;
            step();
            $display("vec %0d: busy=%0b clr=%0b start=%0b done=%0b iter=%0d out=%0d",
                     i, busy, k_clear, k_start, done, iter_cnt, out_cnt);
            chk($sformatf("t1_vec%0d_flags", i), {busy, k_clear, k_start, done},
                {tab[i].e_busy, tab[i].e_clear, tab[i].e_start, tab[i].e_done});
            chk($sformatf("t1_vec%0d_cnts", i), {iter_cnt, out_cnt},
                {tab[i].e_iter, tab[i].e_out});
        end
        chk("t1_err", err_timeout, 1'b0);
        ctrl_start = 1'b0; k_done = 1'b0; k_ready = 1'b0;
        step();

        // Zero iterations: straight to DONE, one busy cycle, no clear or start.
        cfg_n_iter = 16'd0; cfg_n_out = 16'd5; cfg_timeout = 20'd0;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        $display("t2 cycle1: busy=%0b done=%0b clr=%0b start=%0b", busy, done, k_clear, k_start);
        chk("t2_c1", {busy, done, k_clear, k_start}, 4'b1100);
        step();
        $display("t2 cycle2: busy=%0b done=%0b clr=%0b start=%0b", busy, done, k_clear, k_start);
        chk("t2_c2", {busy, done, k_clear, k_start}, 4'b0000);

        // Ready withheld: ten WAIT_RDY cycles, restart one cycle after ready.
        cfg_n_iter = 16'd2; cfg_n_out = 16'd1; cfg_timeout = 20'd0;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        chk("t3_clear", k_clear, 1'b1);
        step();
        chk("t3_start1", k_start, 1'b1);
        step();
        k_done = 1'b1;
        step();
        k_done = 1'b0;
        $display("t3 first done: iter=%0d out=%0d start=%0b", iter_cnt, out_cnt, k_start);
        chk("t3_after_done", {busy, k_start, done}, 3'b100);
        chk("t3_iter1", iter_cnt, 16'd1);
        for (int i = 0; i < 9; i++) begin
            k_done = (i == 4);
            step();
            chk($sformatf("t3_wait%0d", i), {busy, k_start, out_cnt}, {2'b10, 16'd1});
        end
        k_done = 1'b0;
        k_ready = 1'b1;
        step();
        k_ready = 1'b0;
        $display("t3 after ready: start=%0b busy=%0b", k_start, busy);
        chk("t3_start2", {busy, k_start}, 2'b11);
        step();
        k_done = 1'b1;
        step();
        k_done = 1'b0;
        chk("t3_done", {done, iter_cnt}, {1'b1, 16'd2});
        step();
        chk("t3_idle", {busy, done}, 2'b00);

        // Watchdog: no done after start, fires after 50 RUN cycles.
        cfg_n_iter = 16'd1; cfg_n_out = 16'd1; cfg_timeout = 20'd50;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        step();
        chk("t4_start", k_start, 1'b1);
        for (int n = 1; n <= 51; n++) begin
            step();
            if (n == 50) chk("t4_pre_timeout", {busy, err_timeout, k_clear}, 3'b100);
            if (n == 51) begin
                $display("t4 timeout: err=%0b clr=%0b done=%0b", err_timeout, k_clear, done);
                chk("t4_timeout", {busy, err_timeout, k_clear, done}, 4'b1110);
            end
        end
        step();
        chk("t4_after", {busy, err_timeout, k_clear, done}, 4'b0100);
        step();
        step();
        chk("t4_sticky", {busy, err_timeout, done}, 3'b010);

        // Abort together with the last done; a start during ABORT is ignored.
        cfg_n_iter = 16'd1; cfg_n_out = 16'd2; cfg_timeout = 20'd0;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        chk("t5_err_cleared", {err_timeout, k_clear}, 2'b01);
        step();
        step();
        k_done = 1'b1;
        step();
        chk("t5_out1", out_cnt, 16'd1);
        ctrl_abort = 1'b1;
        step();
        ctrl_abort = 1'b0;
        k_done = 1'b0;
        $display("t5 abort: clr=%0b done=%0b busy=%0b out=%0d iter=%0d", k_clear, done, busy, out_cnt, iter_cnt);
        chk("t5_abort", {busy, k_clear, done}, 3'b110);
        chk("t5_not_counted", {iter_cnt, out_cnt}, {16'd0, 16'd1});
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        chk("t5_idle", {busy, k_clear, done}, 3'b000);
        step();
        chk("t5_start_ignored", {busy, k_clear}, 2'b00);

        // Reset mid-RUN, then a normal job with n_out=0 and an ignored start.
        cfg_n_iter = 16'd2; cfg_n_out = 16'd3;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        step();
        step();
        k_done = 1'b1;
        step();
        k_done = 1'b0;
        chk("t6_out1", out_cnt, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("t6 reset: busy=%0b iter=%0d out=%0d", busy, iter_cnt, out_cnt);
        chk("t6_rst_flags", {busy, done, k_clear, k_start, err_timeout}, 5'b0);
        chk("t6_rst_cnts", {iter_cnt, out_cnt}, 32'h0);
        cfg_n_iter = 16'd1; cfg_n_out = 16'd0;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        chk("t6_clear", k_clear, 1'b1);
        step();
        chk("t6_start", k_start, 1'b1);
        step();
        cfg_n_iter = 16'd5; cfg_n_out = 16'd3;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        chk("t6_busy_start_ignored", {busy, k_clear, k_start}, 3'b100);
        k_done = 1'b1;
        step();
        k_done = 1'b0;
        $display("t6 job: done=%0b iter=%0d out=%0d", done, iter_cnt, out_cnt);
        chk("t6_done", {done, iter_cnt, out_cnt}, {1'b1, 16'd1, 16'd1});
        step();
        chk("t6_idle", {busy, done}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
